// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register, operand forwarding/select and decode hazard stall.
// Define OPERAND_FORWARD_EN for M/W forwarding; otherwise RAW hazards stall until the writer reaches W.
module alu_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidD,
  input  logic [31:0] PCD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ImmD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic        UseRs1D,
  input  logic        UseRs2D,
  input  logic        ALUSrcAD,
  input  logic        ALUSrcBD,
  input  logic [3:0]  ALUopD,
  input  logic        RegWriteD,
  input  logic        MemReadD,
  input  logic        MemWriteD,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        RegWriteM,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUOutM,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [31:0] Src1E,
  output logic [31:0] Src2E,
  output logic [3:0]  ALUopE,
  output logic [31:0] WriteDataE,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemReadE,
  output logic        MemWriteE,
  output logic        ValidE,
  output logic        StallD
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        src_a, src_b;
    logic [3:0]  op;
    logic        reg_write, mem_read, mem_write;
  } ex_t;
  ex_t ex, d_in;
  logic [31:0] fwd1, fwd2;
  logic raw_e, raw_m, load_use, hazard;
  assign d_in = '{ValidD, PCD, RD1D, RD2D, ImmD, Rs1D, Rs2D, RdD, ALUSrcAD, ALUSrcBD, ALUopD,
                  RegWriteD & ValidD, MemReadD & ValidD, MemWriteD & ValidD};
  assign raw_e = ValidD && ex.rd != 5'd0 &&
                 ((UseRs1D && Rs1D == ex.rd) || (UseRs2D && Rs2D == ex.rd));
  assign raw_m = ValidD && RdM != 5'd0 &&
                 ((UseRs1D && Rs1D == RdM) || (UseRs2D && Rs2D == RdM));
  assign load_use = ex.valid && ex.mem_read && raw_e;
`ifdef OPERAND_FORWARD_EN
  assign fwd1 = (RegWriteM && RdM != 5'd0 && RdM == ex.rs1) ? ALUOutM :
                (RegWriteW && RdW != 5'd0 && RdW == ex.rs1) ? ResultW : ex.rd1;
  assign fwd2 = (RegWriteM && RdM != 5'd0 && RdM == ex.rs2) ? ALUOutM :
                (RegWriteW && RdW != 5'd0 && RdW == ex.rs2) ? ResultW : ex.rd2;
  assign hazard = load_use;
  logic unused_ok;
  assign unused_ok = raw_m;
`else
  // Without forwarding the register file is the only source, so wait out EX and MEM writers.
  assign fwd1 = ex.rd1;
  assign fwd2 = ex.rd2;
  assign hazard = load_use || (ex.valid && ex.reg_write && raw_e) || (RegWriteM && raw_m);
  logic unused_ok;
  assign unused_ok = ^{ALUOutM, ResultW, RdW, RegWriteW};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ex <= '0;
    else if (FlushE || (!StallE && hazard)) ex <= '0;
    else if (!StallE) ex <= d_in;
  assign Src1E      = ex.src_a ? ex.pc : fwd1;
  assign Src2E      = ex.src_b ? ex.imm : fwd2;
  assign WriteDataE = fwd2;
  assign ALUopE     = ex.op;
  assign RdE        = ex.rd;
  assign RegWriteE  = ex.reg_write;
  assign MemReadE   = ex.mem_read;
  assign MemWriteE  = ex.mem_write;
  assign ValidE     = ex.valid;
  assign StallD     = (hazard || StallE) && !FlushE;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: table vectors with a scoreboard queue plus hazard/flush/reset sequences.
module tb_alu_operand_stage;
`ifdef OPERAND_FORWARD_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic ValidD, UseRs1D, UseRs2D, ALUSrcAD, ALUSrcBD, RegWriteD, MemReadD, MemWriteD;
  logic [31:0] PCD, RD1D, RD2D, ImmD, ALUOutM, ResultW;
  logic [4:0] Rs1D, Rs2D, RdD, RdM, RdW;
  logic [3:0] ALUopD;
  logic StallE = 1'b0, FlushE = 1'b0, RegWriteM, RegWriteW;
  logic [31:0] Src1E, Src2E, WriteDataE;
  logic [3:0] ALUopE;
  logic [4:0] RdE;
  logic RegWriteE, MemReadE, MemWriteE, ValidE, StallD;
  int total = 0, passed = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .ValidD(ValidD), .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
    .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .ALUopD(ALUopD), .RegWriteD(RegWriteD),
    .MemReadD(MemReadD), .MemWriteD(MemWriteD), .StallE(StallE), .FlushE(FlushE),
    .RegWriteM(RegWriteM), .RdM(RdM), .ALUOutM(ALUOutM), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .Src1E(Src1E), .Src2E(Src2E), .ALUopE(ALUopE), .WriteDataE(WriteDataE),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .ValidE(ValidE), .StallD(StallD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        sa, sb;
    logic [3:0]  op;
    logic        v, rw, mr, mw;
    logic        mrw;
    logic [4:0]  mrd;
    logic [31:0] mout;
    logic        wrw;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] e1, e2, ewd;
    logic [3:0]  ectl;
  } vec_t;
  typedef struct {
    logic [31:0] e1, e2, ewd;
    logic [3:0]  op, ctl;
    logic [4:0]  rd;
  } exp_t;
  vec_t tbl[8];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                       input logic [31:0] rd1, rd2, input logic rw, mr, mw);
    ValidD = v; Rs1D = rs1; Rs2D = rs2; RdD = rd; UseRs1D = u1; UseRs2D = u2;
    RD1D = rd1; RD2D = rd2; RegWriteD = rw; MemReadD = mr; MemWriteD = mw;
    PCD = 32'h0; ImmD = 32'h0; ALUSrcAD = 1'b0; ALUSrcBD = 1'b0; ALUopD = 4'h0;
  endtask

  task automatic set_mw(input logic mrw, input logic [4:0] mrd, input logic [31:0] mout,
                        input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    RegWriteM = mrw; RdM = mrd; ALUOutM = mout; RegWriteW = wrw; RdW = wrd; ResultW = wres;
  endtask

  task automatic apply_vec(input vec_t t);
    set_mw(0, 0, 0, 0, 0, 0);
    set_d(t.v, t.rs1, t.rs2, t.rd, 0, 0, t.rd1, t.rd2, t.rw, t.mr, t.mw);
    PCD = t.pc; ImmD = t.imm; ALUSrcAD = t.sa; ALUSrcBD = t.sb; ALUopD = t.op;
    sb.push_back('{t.e1, t.e2, t.ewd, t.op, t.ectl, t.rd});
    tick();
    set_mw(t.mrw, t.mrd, t.mout, t.wrw, t.wrd, t.wres);
    #1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, " Src1E"}, Src1E, e.e1);
    chk({tag, " Src2E"}, Src2E, e.e2);
    chk({tag, " WriteDataE"}, WriteDataE, e.ewd);
    chk({tag, " ALUopE"}, {28'h0, ALUopE}, {28'h0, e.op});
    chk({tag, " RdE"}, {27'h0, RdE}, {27'h0, e.rd});
    chk({tag, " ctl"}, {28'h0, RegWriteE, MemReadE, MemWriteE, ValidE}, {28'h0, e.ctl});
    chk({tag, " StallD"}, {31'h0, StallD}, 32'h0);
  endtask

  initial begin
    tbl[0] = '{32'h40, 32'hAAAA, 32'hBBBB, 0, 5, 6, 7, 0, 0, 4'h3, 1, 1, 0, 0,
               1, 5, 32'h11, 1, 5, 32'h22, FW ? 32'h11 : 32'hAAAA, 32'hBBBB, 32'hBBBB, 4'b1001};
    tbl[1] = '{32'h40, 32'hAAAA, 32'hBBBB, 0, 5, 6, 7, 0, 0, 4'h3, 1, 1, 0, 0,
               0, 5, 32'h11, 1, 5, 32'h22, FW ? 32'h22 : 32'hAAAA, 32'hBBBB, 32'hBBBB, 4'b1001};
    tbl[2] = '{32'h40, 32'hAAAA, 32'hBBBB, 0, 5, 6, 7, 0, 0, 4'h3, 1, 1, 0, 0,
               1, 0, 32'h11, 1, 0, 32'h22, 32'hAAAA, 32'hBBBB, 32'hBBBB, 4'b1001};
    tbl[3] = '{32'h100, 32'h1, 32'h1234, 32'hFFFFFFFC, 2, 9, 8, 1, 1, 4'hA, 1, 1, 0, 0,
               0, 0, 0, 1, 9, 32'h5555, 32'h100, 32'hFFFFFFFC, FW ? 32'h5555 : 32'h1234, 4'b1001};
    tbl[4] = '{32'h10, 32'h3, 32'h4, 32'h5, 1, 2, 6, 0, 0, 4'h1, 0, 1, 1, 1,
               0, 0, 0, 0, 0, 0, 32'h3, 32'h4, 32'h4, 4'b0000};
    tbl[5] = '{32'h20, 32'h1000, 32'h77, 32'h8, 1, 4, 0, 0, 1, 4'h0, 1, 0, 0, 1,
               1, 4, 32'h99, 0, 0, 0, 32'h1000, 32'h8, FW ? 32'h99 : 32'h77, 4'b0011};
    tbl[6] = '{32'h0, 32'h0, 32'h5, 0, 0, 0, 0, 0, 0, 4'h2, 1, 1, 0, 0,
               1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 32'h0, 32'h5, 32'h5, 4'b1001};
    tbl[7] = '{32'h30, 32'h200, 32'h0, 32'h4, 10, 0, 3, 0, 1, 4'h0, 1, 1, 1, 0,
               0, 0, 0, 0, 0, 0, 32'h200, 32'h4, 32'h0, 4'b1101};
    set_mw(0, 0, 0, 0, 0, 0);
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset ValidE", {31'h0, ValidE}, 32'h0);
    chk("reset ctl", {26'h0, RegWriteE, MemReadE, MemWriteE, StallD, ALUopE[1:0]}, 32'h0);
    chk("reset Src1E/Src2E/WD", Src1E | Src2E | WriteDataE | {27'h0, RdE} | {28'h0, ALUopE}, 32'h0);
    #5 rst_n = 1'b1;
    foreach (tbl[i]) begin
      apply_vec(tbl[i]);
      check_out($sformatf("vec%0d", i));
    end
    // asynchronous reset with a valid instruction in EX
    set_mw(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset ValidE", {31'h0, ValidE}, 32'h0);
    chk("midreset outs", Src1E | Src2E | WriteDataE | {27'h0, RdE} |
        {28'h0, RegWriteE, MemReadE, MemWriteE, StallD}, 32'h0);
    #1 rst_n = 1'b1;
    apply_vec(tbl[1]);
    check_out("post-reset");
    // load-use: lw x3 then add x4,x3,x2
    set_mw(0, 0, 0, 0, 0, 0);
    set_d(1, 1, 0, 3, 1, 0, 32'h100, 0, 1, 1, 0);
    tick();
    chk("lw in EX MemReadE", {31'h0, MemReadE}, 32'h1);
    set_d(1, 3, 2, 4, 1, 1, 32'h0, 32'h20, 1, 0, 0);
    #1 chk("loaduse StallD", {31'h0, StallD}, 32'h1);
    tick();
    set_mw(1, 3, 32'hBAD, 0, 0, 0);
    #1 chk("loaduse bubble ValidE", {31'h0, ValidE}, 32'h0);
    chk("loaduse bubble RegWriteE", {31'h0, RegWriteE}, 32'h0);
`ifdef OPERAND_FORWARD_EN
    chk("loaduse StallD released", {31'h0, StallD}, 32'h0);
    tick();
    set_mw(0, 0, 0, 1, 3, 32'hCAFE);
    #1 chk("loaduse add ValidE", {31'h0, ValidE}, 32'h1);
    chk("loaduse add Src1E W fwd", Src1E, 32'hCAFE);
    chk("loaduse add Src2E", Src2E, 32'h20);
`else
    chk("loaduse StallD M writer", {31'h0, StallD}, 32'h1);
    tick();
    set_mw(0, 0, 0, 1, 3, 32'hCAFE);
    RD1D = 32'hCAFE;
    #1 chk("loaduse 2nd bubble ValidE", {31'h0, ValidE}, 32'h0);
    chk("loaduse StallD released", {31'h0, StallD}, 32'h0);
    tick();
    set_mw(0, 0, 0, 0, 0, 0);
    #1 chk("loaduse add ValidE", {31'h0, ValidE}, 32'h1);
    chk("loaduse add Src1E", Src1E, 32'hCAFE);
    chk("loaduse add Src2E", Src2E, 32'h20);
`endif
    // flush beats a pending load-use hazard
    set_mw(0, 0, 0, 0, 0, 0);
    set_d(1, 1, 0, 3, 1, 0, 32'h100, 0, 1, 1, 0);
    tick();
    set_d(1, 3, 2, 4, 1, 1, 32'h0, 32'h20, 1, 0, 0);
    FlushE = 1'b1;
    #1 chk("flush+hazard StallD", {31'h0, StallD}, 32'h0);
    tick();
    FlushE = 1'b0;
    chk("flush bubble ValidE", {31'h0, ValidE}, 32'h0);
    chk("flush bubble RdE", {27'h0, RdE}, 32'h0);
    // StallE holds EX; flush overrides StallE
    set_d(1, 0, 0, 9, 0, 0, 32'h9, 0, 1, 0, 0);
    tick();
    StallE = 1'b1;
    set_d(1, 0, 0, 10, 0, 0, 32'hA, 0, 1, 0, 0);
    #1 chk("StallE StallD", {31'h0, StallD}, 32'h1);
    tick();
    chk("StallE hold RdE", {27'h0, RdE}, 32'd9);
    chk("StallE hold Src1E", Src1E, 32'h9);
    FlushE = 1'b1;
    #1 chk("flush+StallE StallD", {31'h0, StallD}, 32'h0);
    tick();
    StallE = 1'b0;
    FlushE = 1'b0;
    chk("flush+StallE bubble", {31'h0, ValidE}, 32'h0);
    // add x1 followed by dependent sub x5,x1,x2
    set_mw(0, 0, 0, 0, 0, 0);
    set_d(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    tick();
    set_d(1, 1, 2, 5, 1, 1, 32'h1, 32'h2, 1, 0, 0);
    #1 chk("raw StallD", {31'h0, StallD}, FW ? 32'h0 : 32'h1);
`ifdef OPERAND_FORWARD_EN
    tick();
    set_mw(1, 1, 32'h42, 0, 0, 0);
    #1 chk("raw sub ValidE", {31'h0, ValidE}, 32'h1);
    chk("raw sub Src1E M fwd", Src1E, 32'h42);
    chk("raw sub RdE", {27'h0, RdE}, 32'd5);
`else
    tick();
    set_mw(1, 1, 32'h42, 0, 0, 0);
    #1 chk("raw bubble1 ValidE", {31'h0, ValidE}, 32'h0);
    chk("raw stall2 StallD", {31'h0, StallD}, 32'h1);
    tick();
    set_mw(0, 0, 0, 1, 1, 32'h42);
    RD1D = 32'h42;
    #1 chk("raw bubble2 ValidE", {31'h0, ValidE}, 32'h0);
    chk("raw StallD released", {31'h0, StallD}, 32'h0);
    tick();
    set_mw(0, 0, 0, 0, 0, 0);
    #1 chk("raw sub ValidE", {31'h0, ValidE}, 32'h1);
    chk("raw sub Src1E", Src1E, 32'h42);
    chk("raw sub RdE", {27'h0, RdE}, 32'd5);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline register plus EX-stage operand selection for the 5-stage RV32I core. Captures decoded operands and control from decode, forwards in-flight results from MEM/WB, and drives the ALU's two 32-bit sources and 4-bit operation code. Contains the load-use hazard detector that stalls decode and inserts bubbles into EX.

## Interface
- No parameters; data width fixed at 32, register index 5 bits.
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ValidD  in  1  decode slot holds a real instruction
- PCD, RD1D, RD2D, ImmD  in  32 each  PC, register-file reads, sign-extended immediate
- Rs1D, Rs2D, RdD  in  5 each  source/destination indices
- UseRs1D, UseRs2D  in  1 each  instruction actually reads rs1/rs2
- ALUSrcAD  in  1  0 = rs1, 1 = PC
- ALUSrcBD  in  1  0 = rs2, 1 = ImmD
- ALUopD  in  4  ALU operation code
- RegWriteD, MemReadD, MemWriteD  in  1 each  writeback / load / store
- StallE  in  1  external hold of EX (memory busy)
- FlushE  in  1  kill instruction entering EX (taken branch/jump)
- RegWriteM, RdM, ALUOutM  in  1/5/32  EX/MEM result
- RegWriteW, RdW, ResultW  in  1/5/32  MEM/WB result
- Src1E, Src2E  out  32 each  ALU sources
- ALUopE  out  4  ALU operation
- WriteDataE  out  32  forwarded rs2 value for stores
- RdE, RegWriteE, MemReadE, MemWriteE, ValidE  out  5/1/1/1/1  EX control
- StallD  out  1  hold PC and IF/ID

## Operation
- EX register holds: Valid, PC, RD1, RD2, Imm, Rs1, Rs2, Rd, ALUSrcA/B, ALUop, RegWrite, MemRead, MemWrite.
- Per rising edge, priority: FlushE -> load bubble (all control 0, ValidE 0, data regs don't-care but zeroed); else StallE -> hold; else hazard -> bubble; else capture D-side.
- RegWrite/MemRead/MemWrite are stored ANDed with ValidD.
- Forwarding (combinational, on registered Rs1E/Rs2E): if RegWriteM & RdM!=0 & RdM==RsXE use ALUOutM; else if RegWriteW & RdW!=0 & RdW==RsXE use ResultW; else RDXE. M has priority over W. x0 never forwarded.
- Src1E = ALUSrcAE ? PCE : fwd1; Src2E = ALUSrcBE ? ImmE : fwd2; WriteDataE = fwd2 always.
- Load-use hazard: ValidE & MemReadE & RdE!=0 & ValidD & ((UseRs1D & Rs1D==RdE) | (UseRs2D & Rs2D==RdE)).
- StallD = (hazard | StallE) & ~FlushE.
- Register file is write-first, so W-stage dependencies at decode need no stall.

## Timing
- Reset: all EX regs 0; ValidE, RegWriteE, MemReadE, MemWriteE, StallD = 0; ALUopE = 4'b0000; RdE = 0; Src1E, Src2E, WriteDataE = 0 (given M/W inputs inactive).
- Capture latency 1 cycle D -> E; forwarding and Src muxes have 0-cycle latency from M/W inputs.
- Load-use costs exactly one bubble: hazard cycle N -> StallD=1, bubble in EX at N+1; at N+1 load sits in MEM and result arrives via W forward at N+2 when dependent instruction enters EX.
- FlushE with simultaneous hazard: flush wins, StallD=0.
- FlushE with StallE: flush wins (bubble).
- Reset asserted mid-operation: all state returns to reset values asynchronously; no partial capture on release edge.

## Configuration
- OPERAND_FORWARD_EN defined: forwarding as above; only load-use stalls.
- Undefined: no forwarding muxes (fwdX = RDXE); hazard extends to any RAW with valid writer in EX (RegWriteE, RdE!=0) or MEM (RegWriteM, RdM!=0); StallD held until producer reaches W; each stall cycle inserts one bubble.

## Test plan
- Reset: rst_n=0 mid-stream with ValidE=1 -> all outputs 0 immediately; first capture after release is normal.
- Forward priority: RdM=RdW=5, ALUOutM=0x11, ResultW=0x22, Rs1E=5, ALUSrcAE=0 -> Src1E=0x11; drop RegWriteM -> 0x22; RdM=RdW=0 -> RD1E.
- Immediate/PC select: ALUSrcA=1, ALUSrcB=1, PCD=0x100, ImmD=0xFFFFFFFC -> Src1E=0x100, Src2E=0xFFFFFFFC, WriteDataE still forwarded rs2.
- Load-use: lw x3 in EX, add reads x3 in D -> StallD=1 one cycle, ValidE=0 next cycle, then add in EX gets ResultW via W forward.
- Flush vs hazard: load-use condition plus FlushE=1 -> StallD=0, bubble in EX.
- Without OPERAND_FORWARD_EN: add x1 followed by dependent sub x1 -> StallD=1 for 2 cycles, 2 bubbles, sub sees updated RD1.
